lc3_ctrl_fsm: RTL and testbench
===============================

// Module: lc3_ctrl_fsm
// PURPOSE
//  Parametrised LC-3 control FSM: fetch/decode/execute sequencing for the SLC-3 datapath.
//  Emits load enables, bus gates, mux selects and active-low SRAM strobes.
//  Memory wait states are set by a parameter; one counter replaces fixed split states.
//  Optional PAUSE opcode. Sits between IR/BEN/nzp logic and the datapath/SRAM.
// PARAMETERS
//  MEM_WAIT  2  SRAM access cycles per read/write (>=1); OE/WE held low this many cycles
//  PAUSE_EN  1  1: opcode 4'b1101 enters PauseIR1/2; 0: 1101 is illegal
// PORTS
//  Clk        in   1  clock, all state updates on rising edge
//  Reset      in   1  asynchronous, active-high; forces Halted
//  Run        in   1  start from Halted (level)
//  Continue   in   1  PAUSE release, press-then-release handshake
//  Opcode     in   4  IR[15:12]
//  IR_5       in   1  immediate select for ADD/AND
//  IR_11      in   1  JSR(1)/JSRR(0)
//  BEN        in   1  branch enable from BEN register
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out 1 each  register loads
//  GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers (one-hot or none)
//  PCMUX  out 2  00 PC+1, 01 bus, 10 adder      DRMUX out 1  0 IR[11:9], 1 R7
//  SR1MUX out 1  0 IR[11:9], 1 IR[8:6]          SR2MUX out 1  0 reg, 1 imm5
//  ADDR1MUX out 1 0 PC, 1 BaseR   ADDR2MUX out 2 00 zero,01 off6,10 off9,11 off11
//  ALUK   out 2  00 ADD, 01 AND, 10 NOT, 11 PASSA
//  Mem_CE, Mem_UB, Mem_LB  out 1  tied 0;  Mem_OE, Mem_WE  out 1  active-low strobes
// BEHAVIOUR
//  Moore outputs decoded from state. Defaults: all LD/Gate/mux/ALUK 0, Mem_OE=Mem_WE=1.
//  Reset (async, any cycle): State=Halted, wait_cnt=0. Outputs = defaults immediately.
//  Mid-access reset releases OE/WE in that same cycle.
//  Halted -> S_18 when Run=1, else stay. Run ignored in all other states.
//  Fetch: S_18 (GatePC,LD_MAR,LD_PC,PCMUX=00) -> S_33 (OE=0, MEM_WAIT cycles,
//   LD_MDR only in final cycle) -> S_35 (GateMDR,LD_IR) -> S_32 (LD_BEN) -> decode.
//  Fetch-to-decode latency = MEM_WAIT+3 cycles.
//  Decode: 0001 S_01, 0101 S_05, 1001 S_09, 0000 S_00, 1100 S_12, 0100 S_04,
//   0110 S_06, 0111 S_07, 1101 PauseIR1 (if PAUSE_EN), all others -> S_18.
//  S_01/S_05: SR1MUX=1, SR2MUX=IR_5, ALUK 00/01, GateALU, LD_REG, LD_CC -> S_18.
//  S_09: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC -> S_18.
//  S_00: BEN ? S_22 : S_18. S_22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S_18.
//  S_12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S_18.
//  S_04: GatePC, DRMUX=1, LD_REG -> IR_11 ? S_21 : S_20.
//   S_21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S_18.
//   S_20: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S_18.
//   R7 takes PC (already PC+1) before PC updates; JSRR R7 reads old BaseR.
//  S_06/S_07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S_25 / S_23.
//  S_25: OE=0 MEM_WAIT cycles, LD_MDR final cycle -> S_27 (GateMDR,LD_REG,LD_CC) -> S_18.
//  S_23: SR1MUX=0, ALUK=11, GateALU, LD_MDR -> S_16: WE=0 (OE=1) MEM_WAIT cycles -> S_18.
//  PauseIR1: LD_LED=1; stay while Continue=0, ->PauseIR2 on 1. PauseIR2: stay while 1, ->S_18 on 0.
//  wait_cnt: loads 0 on entry to S_33/S_25/S_16; increments; exit when wait_cnt==MEM_WAIT-1.
//   Width $clog2(MEM_WAIT+1); MEM_WAIT=1 gives single-cycle access, no counter wrap.
//  OE and WE never low in the same cycle. At most one Gate* high any cycle.
//  Unreachable/illegal state encodings -> S_18.
// STRUCTURE
//  lc3_ctrl_pkg: state_t enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings.
//  Sub-module mem_wait_timer (start, done; param MEM_WAIT): owns wait_cnt.
//  Top holds state register, next-state comb block, output comb block.
// TESTING
//  Reset mid-S_33, MEM_WAIT=2 -> Mem_OE=1 same cycle; Halted; no LD_* until Run.
//  Run=1, MEM_WAIT=3, IR=0x1283 (ADD) -> LD_IR 5 cycles after S_18, then S_32, S_01 (GateALU,LD_REG,SR2MUX=0).
//  IR=0x0E05 BR, BEN=1 -> S_22 with PCMUX=10, ADDR2MUX=10; BEN=0 -> S_18 next cycle.
//  IR=0x4802 JSR -> S_04 (DRMUX=1,GatePC) -> S_21 (ADDR2MUX=11); IR=0x4080 -> S_20.
//  IR=0x7042 STR, MEM_WAIT=4 -> S_23 LD_MDR, then Mem_WE=0 exactly 4 cycles, OE=1 throughout.
//  PAUSE_EN=1, IR=0xD000: LD_LED until Continue pulse 1->0 then S_18; PAUSE_EN=0: straight to S_18.

Source files
------------

// File: rtl/lc3_ctrl_fsm_pkg.sv
// Shared encodings for the LC-3 control FSM: state codes, opcodes and datapath mux selects.
// State codes are plain 5-bit constants so legacy code can compare against them directly.
package lc3_ctrl_fsm_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_HALTED = 5'd0;
  localparam state_t S_18     = 5'd1;
  localparam state_t S_33     = 5'd2;
  localparam state_t S_35     = 5'd3;
  localparam state_t S_32     = 5'd4;
  localparam state_t S_01     = 5'd5;
  localparam state_t S_05     = 5'd6;
  localparam state_t S_09     = 5'd7;
  localparam state_t S_00     = 5'd8;
  localparam state_t S_22     = 5'd9;
  localparam state_t S_12     = 5'd10;
  localparam state_t S_04     = 5'd11;
  localparam state_t S_21     = 5'd12;
  localparam state_t S_20     = 5'd13;
  localparam state_t S_06     = 5'd14;
  localparam state_t S_07     = 5'd15;
  localparam state_t S_25     = 5'd16;
  localparam state_t S_27     = 5'd17;
  localparam state_t S_23     = 5'd18;
  localparam state_t S_16     = 5'd19;
  localparam state_t S_PAUSE1 = 5'd20;
  localparam state_t S_PAUSE2 = 5'd21;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // States whose successor is a memory wait state, so the wait counter must restart.
  function automatic logic wait_entry(input state_t s);
    return (s == S_18) || (s == S_06) || (s == S_23);
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// Control bundle between the LC-3 sequencer (master) and the IR/datapath/SRAM side (slave).
interface lc3_ctrl_fsm_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_ctrl_fsm_mem_wait_timer.sv
// SRAM access timer: restarts at zero on start and flags the last cycle of a MEM_WAIT-long access.
module lc3_ctrl_fsm_mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic done
);
  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] wait_cnt_r;

  // Counter saturates on the last cycle so it never wraps while parked outside a wait state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt_r <= CNT_W'(0);
    end else if (start) begin
      wait_cnt_r <= CNT_W'(0);
    end else if (!done) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign done = (wait_cnt_r == CNT_LAST);
endmodule

// File: rtl/lc3_ctrl_fsm.sv
// SLC-3 fetch/decode/execute sequencer with Moore-decoded control outputs and a
// parameterised SRAM wait length; optional PAUSE opcode.
module lc3_ctrl_fsm
  import lc3_ctrl_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  lc3_ctrl_fsm_if.master     bus
);
  state_t state_r;
  state_t next_state_s;
  logic   wait_start_s;
  logic   wait_done_s;

  assign wait_start_s = wait_entry(state_r);

  lc3_ctrl_fsm_mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .start (wait_start_s),
    .done  (wait_done_s)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= S_HALTED;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; any encoding outside the table recovers through fetch.
  always_comb begin
    next_state_s = S_18;
    case (state_r)
      S_HALTED: begin
        if (bus.Run) next_state_s = S_18;
        else         next_state_s = S_HALTED;
      end
      S_18: next_state_s = S_33;
      S_33: begin
        if (wait_done_s) next_state_s = S_35;
        else             next_state_s = S_33;
      end
      S_35: next_state_s = S_32;
      S_32: begin
        case (bus.Opcode)
          OP_ADD:  next_state_s = S_01;
          OP_AND:  next_state_s = S_05;
          OP_NOT:  next_state_s = S_09;
          OP_BR:   next_state_s = S_00;
          OP_JMP:  next_state_s = S_12;
          OP_JSR:  next_state_s = S_04;
          OP_LDR:  next_state_s = S_06;
          OP_STR:  next_state_s = S_07;
          OP_PSE: begin
            if (PAUSE_EN) next_state_s = S_PAUSE1;
            else          next_state_s = S_18;
          end
          default: next_state_s = S_18;
        endcase
      end
      S_00: begin
        if (bus.BEN) next_state_s = S_22;
        else         next_state_s = S_18;
      end
      S_04: begin
        if (bus.IR_11) next_state_s = S_21;
        else           next_state_s = S_20;
      end
      S_06: next_state_s = S_25;
      S_25: begin
        if (wait_done_s) next_state_s = S_27;
        else             next_state_s = S_25;
      end
      S_07: next_state_s = S_23;
      S_23: next_state_s = S_16;
      S_16: begin
        if (wait_done_s) next_state_s = S_18;
        else             next_state_s = S_16;
      end
      S_PAUSE1: begin
        if (bus.Continue) next_state_s = S_PAUSE2;
        else              next_state_s = S_PAUSE1;
      end
      S_PAUSE2: begin
        if (bus.Continue) next_state_s = S_PAUSE2;
        else              next_state_s = S_18;
      end
      default: next_state_s = S_18;
    endcase
  end

  // Moore output decode; strobes are active-low and only one bus gate is ever raised.
  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = PCMUX_PC1;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.Mem_CE     = 1'b0;
    bus.Mem_UB     = 1'b0;
    bus.Mem_LB     = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    case (state_r)
      S_18: begin
        bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1; bus.PCMUX = PCMUX_PC1;
      end
      S_33: begin
        bus.Mem_OE = 1'b0; bus.LD_MDR = wait_done_s;
      end
      S_35: begin
        bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
      end
      S_32: bus.LD_BEN = 1'b1;
      S_01, S_05: begin
        bus.SR1MUX = 1'b1; bus.SR2MUX = bus.IR_5;
        bus.ALUK   = (state_r == S_05) ? ALUK_AND : ALUK_ADD;
        bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      S_09: begin
        bus.SR1MUX = 1'b1; bus.ALUK = ALUK_NOT;
        bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      S_22: begin
        bus.ADDR1MUX = 1'b0; bus.ADDR2MUX = ADDR2_OFF9; bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
      end
      S_12, S_20: begin
        bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_ZERO;
        bus.PCMUX  = PCMUX_ADDER; bus.LD_PC = 1'b1;
      end
      // PC already holds the return address here, so R7 is written before PC moves.
      S_04: begin
        bus.GatePC = 1'b1; bus.DRMUX = 1'b1; bus.LD_REG = 1'b1;
      end
      S_21: begin
        bus.ADDR1MUX = 1'b0; bus.ADDR2MUX = ADDR2_OFF11; bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
      end
      S_06, S_07: begin
        bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_OFF6;
        bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
      end
      S_25: begin
        bus.Mem_OE = 1'b0; bus.LD_MDR = wait_done_s;
      end
      S_27: begin
        bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      S_23: begin
        bus.SR1MUX = 1'b0; bus.ALUK = ALUK_PASSA; bus.GateALU = 1'b1; bus.LD_MDR = 1'b1;
      end
      S_16: bus.Mem_WE = 1'b0;
      S_PAUSE1, S_PAUSE2: bus.LD_LED = 1'b1;
      default: bus.LD_LED = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm across four parameter sets; expected control words are
// queued as stimulus is applied and compared after the following clock edge.
module tb_lc3_ctrl_fsm;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic ce, ub, lb, oe, we;
  } ctrl_t;

  typedef struct {
    int    dut;
    ctrl_t exp;
    string tag;
  } sb_t;

  localparam int B_HALT = 0,  B_18 = 1,  B_33 = 2,  B_35 = 3,  B_32 = 4,  B_01 = 5;
  localparam int B_05   = 6,  B_09 = 7,  B_00 = 8,  B_22 = 9,  B_12 = 10, B_04 = 11;
  localparam int B_21   = 12, B_20 = 13, B_06 = 14, B_07 = 15, B_25 = 16, B_27 = 17;
  localparam int B_23   = 18, B_16 = 19, B_P1 = 20, B_P2 = 21;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       run, cont, ir5, ir11, ben;
  logic [3:0] opcode;
  sb_t        sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  ctrl_t      obs1, obs2, obs3, obs4;

  always #5 Clk = ~Clk;

  lc3_ctrl_fsm_if if1 ();
  lc3_ctrl_fsm_if if2 ();
  lc3_ctrl_fsm_if if3 ();
  lc3_ctrl_fsm_if if4 ();

  assign if1.Run = run; assign if1.Continue = cont; assign if1.Opcode = opcode;
  assign if1.IR_5 = ir5; assign if1.IR_11 = ir11; assign if1.BEN = ben;
  assign if2.Run = run; assign if2.Continue = cont; assign if2.Opcode = opcode;
  assign if2.IR_5 = ir5; assign if2.IR_11 = ir11; assign if2.BEN = ben;
  assign if3.Run = run; assign if3.Continue = cont; assign if3.Opcode = opcode;
  assign if3.IR_5 = ir5; assign if3.IR_11 = ir11; assign if3.BEN = ben;
  assign if4.Run = run; assign if4.Continue = cont; assign if4.Opcode = opcode;
  assign if4.IR_5 = ir5; assign if4.IR_11 = ir11; assign if4.BEN = ben;

  lc3_ctrl_fsm #(.MEM_WAIT(1), .PAUSE_EN(1'b0)) dut1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  lc3_ctrl_fsm #(.MEM_WAIT(2), .PAUSE_EN(1'b1)) dut2 (.Clk(Clk), .Reset(Reset), .bus(if2));
  lc3_ctrl_fsm #(.MEM_WAIT(3), .PAUSE_EN(1'b1)) dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));
  lc3_ctrl_fsm #(.MEM_WAIT(4), .PAUSE_EN(1'b0)) dut4 (.Clk(Clk), .Reset(Reset), .bus(if4));

  assign obs1 = {if1.LD_MAR, if1.LD_MDR, if1.LD_IR, if1.LD_BEN, if1.LD_CC, if1.LD_REG, if1.LD_PC,
                 if1.LD_LED, if1.GatePC, if1.GateMDR, if1.GateALU, if1.GateMARMUX, if1.PCMUX,
                 if1.DRMUX, if1.SR1MUX, if1.SR2MUX, if1.ADDR1MUX, if1.ADDR2MUX, if1.ALUK,
                 if1.Mem_CE, if1.Mem_UB, if1.Mem_LB, if1.Mem_OE, if1.Mem_WE};
  assign obs2 = {if2.LD_MAR, if2.LD_MDR, if2.LD_IR, if2.LD_BEN, if2.LD_CC, if2.LD_REG, if2.LD_PC,
                 if2.LD_LED, if2.GatePC, if2.GateMDR, if2.GateALU, if2.GateMARMUX, if2.PCMUX,
                 if2.DRMUX, if2.SR1MUX, if2.SR2MUX, if2.ADDR1MUX, if2.ADDR2MUX, if2.ALUK,
                 if2.Mem_CE, if2.Mem_UB, if2.Mem_LB, if2.Mem_OE, if2.Mem_WE};
  assign obs3 = {if3.LD_MAR, if3.LD_MDR, if3.LD_IR, if3.LD_BEN, if3.LD_CC, if3.LD_REG, if3.LD_PC,
                 if3.LD_LED, if3.GatePC, if3.GateMDR, if3.GateALU, if3.GateMARMUX, if3.PCMUX,
                 if3.DRMUX, if3.SR1MUX, if3.SR2MUX, if3.ADDR1MUX, if3.ADDR2MUX, if3.ALUK,
                 if3.Mem_CE, if3.Mem_UB, if3.Mem_LB, if3.Mem_OE, if3.Mem_WE};
  assign obs4 = {if4.LD_MAR, if4.LD_MDR, if4.LD_IR, if4.LD_BEN, if4.LD_CC, if4.LD_REG, if4.LD_PC,
                 if4.LD_LED, if4.GatePC, if4.GateMDR, if4.GateALU, if4.GateMARMUX, if4.PCMUX,
                 if4.DRMUX, if4.SR1MUX, if4.SR2MUX, if4.ADDR1MUX, if4.ADDR2MUX, if4.ALUK,
                 if4.Mem_CE, if4.Mem_UB, if4.Mem_LB, if4.Mem_OE, if4.Mem_WE};

  // Expected control word for each state, written from the state/output table.
  function automatic ctrl_t ctrl_for(input int st, input bit last, input bit imm);
    ctrl_t c;
    c = '0;
    c.oe = 1'b1;
    c.we = 1'b1;
    case (st)
      B_18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00; end
      B_33, B_25: begin c.oe = 1'b0; c.ld_mdr = last; end
      B_35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      B_32: c.ld_ben = 1'b1;
      B_01, B_05: begin
        c.sr1mux = 1'b1; c.sr2mux = imm; c.aluk = (st == B_05) ? 2'b01 : 2'b00;
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      B_09: begin
        c.sr1mux = 1'b1; c.aluk = 2'b10; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      B_22: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      B_12, B_20: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b00; c.pcmux = 2'b10; c.ld_pc = 1'b1;
      end
      B_04: begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
      B_21: begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      B_06, B_07: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      B_27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      B_23: begin c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; end
      B_16: c.we = 1'b0;
      B_P1, B_P2: c.ld_led = 1'b1;
      default: c.ld_led = 1'b0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t obs_of(input int d);
    case (d)
      1: return obs1;
      2: return obs2;
      3: return obs3;
      4: return obs4;
      default: return '0;
    endcase
  endfunction

  task automatic expect_st(input int d, input int st, input bit last, input string tag);
    sb_t e;
    e.dut = d;
    e.exp = ctrl_for(st, last, ir5);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    sb_t   e;
    ctrl_t o;
    e = sb_q.pop_front();
    o = obs_of(e.dut);
    n_cmp++;
    assert (o === e.exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.exp);
    end
  endtask

  task automatic step(input int d, input int st, input bit last, input string tag);
    expect_st(d, st, last, tag);
    @(posedge Clk);
    #1;
    compare_front();
  endtask

  task automatic fetch(input int d, input int mw, input string tag);
    for (int i = 0; i < mw; i++) step(d, B_33, (i == mw - 1), {tag, "-s33"});
    step(d, B_35, 1'b0, {tag, "-s35"});
    step(d, B_32, 1'b0, {tag, "-s32"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; run = 1'b0; cont = 1'b0; opcode = 4'b0000;
    ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    for (int d = 1; d <= 4; d++) begin
      expect_st(d, B_HALT, 1'b0, "reset-halted");
      compare_front();
    end
    Reset = 1'b0;
    step(2, B_HALT, 1'b0, "no-run-halted");

    // MEM_WAIT=2: asynchronous reset in the middle of the fetch read.
    run = 1'b1;
    step(2, B_18, 1'b0, "mw2-run-s18");
    run = 1'b0;
    step(2, B_33, 1'b0, "mw2-s33-c0");
    #2 Reset = 1'b1;
    #1;
    expect_st(2, B_HALT, 1'b0, "mid-s33-reset-oe");
    compare_front();
    step(2, B_HALT, 1'b0, "reset-held");
    Reset = 1'b0;
    step(2, B_HALT, 1'b0, "post-reset-no-run-1");
    step(2, B_HALT, 1'b0, "post-reset-no-run-2");

    // MEM_WAIT=3, PAUSE_EN=1: every instruction class.
    opcode = 4'b0001; ir5 = 1'b0; ir11 = 1'b0;
    run = 1'b1;
    step(3, B_18, 1'b0, "add-s18");
    run = 1'b0;
    fetch(3, 3, "add");
    step(3, B_01, 1'b0, "add-s01");
    step(3, B_18, 1'b0, "add-done");

    opcode = 4'b0101; ir5 = 1'b1;
    fetch(3, 3, "and");
    step(3, B_05, 1'b0, "and-s05");
    step(3, B_18, 1'b0, "and-done");

    opcode = 4'b1001; ir5 = 1'b0; run = 1'b1;
    fetch(3, 3, "not-runheld");
    step(3, B_09, 1'b0, "not-s09");
    step(3, B_18, 1'b0, "not-done");
    run = 1'b0;

    opcode = 4'b0000; ben = 1'b1;
    fetch(3, 3, "br-taken");
    step(3, B_00, 1'b0, "br-s00");
    step(3, B_22, 1'b0, "br-s22");
    step(3, B_18, 1'b0, "br-taken-done");

    ben = 1'b0;
    fetch(3, 3, "br-not");
    step(3, B_00, 1'b0, "brn-s00");
    step(3, B_18, 1'b0, "brn-s18");

    opcode = 4'b0100; ir11 = 1'b1;
    fetch(3, 3, "jsr");
    step(3, B_04, 1'b0, "jsr-s04");
    step(3, B_21, 1'b0, "jsr-s21");
    step(3, B_18, 1'b0, "jsr-done");

    ir11 = 1'b0;
    fetch(3, 3, "jsrr");
    step(3, B_04, 1'b0, "jsrr-s04");
    step(3, B_20, 1'b0, "jsrr-s20");
    step(3, B_18, 1'b0, "jsrr-done");

    opcode = 4'b1100;
    fetch(3, 3, "jmp");
    step(3, B_12, 1'b0, "jmp-s12");
    step(3, B_18, 1'b0, "jmp-done");

    opcode = 4'b0110;
    fetch(3, 3, "ldr");
    step(3, B_06, 1'b0, "ldr-s06");
    for (int i = 0; i < 3; i++) step(3, B_25, (i == 2), "ldr-s25");
    step(3, B_27, 1'b0, "ldr-s27");
    step(3, B_18, 1'b0, "ldr-done");

    opcode = 4'b1000;
    fetch(3, 3, "illegal");
    step(3, B_18, 1'b0, "illegal-s18");

    opcode = 4'b1101;
    fetch(3, 3, "pause");
    step(3, B_P1, 1'b0, "pause1-a");
    step(3, B_P1, 1'b0, "pause1-b");
    cont = 1'b1;
    step(3, B_P2, 1'b0, "pause2-a");
    step(3, B_P2, 1'b0, "pause2-b");
    cont = 1'b0;
    step(3, B_18, 1'b0, "pause-release");

    // MEM_WAIT=4, PAUSE_EN=0: store write strobe length, PAUSE treated as illegal.
    Reset = 1'b1;
    step(4, B_HALT, 1'b0, "mw4-reset");
    Reset = 1'b0;
    opcode = 4'b0111; run = 1'b1;
    step(4, B_18, 1'b0, "str-s18");
    run = 1'b0;
    fetch(4, 4, "str");
    step(4, B_07, 1'b0, "str-s07");
    step(4, B_23, 1'b0, "str-s23");
    for (int i = 0; i < 4; i++) step(4, B_16, 1'b0, "str-s16-we");
    step(4, B_18, 1'b0, "str-done");
    opcode = 4'b1101;
    fetch(4, 4, "pse-off");
    step(4, B_18, 1'b0, "pause-disabled");

    // MEM_WAIT=1: single-cycle access.
    Reset = 1'b1;
    step(1, B_HALT, 1'b0, "mw1-reset");
    Reset = 1'b0;
    opcode = 4'b0001; ir5 = 1'b1; run = 1'b1;
    step(1, B_18, 1'b0, "mw1-s18");
    run = 1'b0;
    fetch(1, 1, "mw1");
    step(1, B_01, 1'b0, "mw1-s01");
    step(1, B_18, 1'b0, "mw1-done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
